// File: rtl/exu_ctrl.sv
// Execute-stage controller: accepts decoded instructions, sequences ALU/MDU/memory
// completion, retires with a write-back strobe, and handles flushes and load-use bubbles.
module exu_ctrl #(
  parameter int         XREG_ADDRWIDTH = 5,
  parameter logic [6:0] OPCODE_ALR     = 7'b0110011,
  parameter logic [6:0] OPCODE_LOAD    = 7'b0000011,
  parameter logic [6:0] OPCODE_STORE   = 7'b0100011,
  parameter logic [6:0] OPCODE_BRANCH  = 7'b1100011
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid_in,
  output logic                      id_ready_out,
  input  logic [6:0]                id_opcode_in,
  input  logic [6:0]                id_func7_in,
  input  logic                      id_rd_en_in,
  input  logic [XREG_ADDRWIDTH-1:0] id_rd_addr_in,
  input  logic [XREG_ADDRWIDTH-1:0] id_rs1_addr_in,
  input  logic [XREG_ADDRWIDTH-1:0] id_rs2_addr_in,
  input  logic                      alu_branch_flag_in,
  input  logic                      mem_ready_in,
  output logic                      mdu_start_out,
  input  logic                      mdu_done_in,
  output logic                      ex_valid_out,
  output logic                      flush_out,
  output logic                      wb_en_out,
  output logic [XREG_ADDRWIDTH-1:0] wb_rd_addr_out,
  output logic [31:0]               retire_cnt_out,
  output logic                      exu_err_out
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_EXEC  = 3'd1;
  localparam logic [2:0] ST_MDU   = 3'd2;
  localparam logic [2:0] ST_MEM   = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  localparam logic [XREG_ADDRWIDTH-1:0] X0 = {XREG_ADDRWIDTH{1'b0}};
  localparam logic [5:0] MDU_LIMIT = 6'd63;

  logic [2:0]                r_state;
  logic [6:0]                r_opcode;
  logic [6:0]                r_func7;
  logic                      r_rd_en;
  logic [XREG_ADDRWIDTH-1:0] r_rd_addr;
  logic [5:0]                r_mdu_cnt;
  logic [31:0]               r_retire_cnt;
  logic                      r_err;
  logic                      r_ex_valid;

  logic [2:0] w_next_state;
  logic       w_ready;
  logic       w_flush;
  logic       w_start;
  logic       w_retire;
  logic       w_timeout;
  logic       w_accept;
  logic       w_hazard;
  logic       w_is_ls;
  logic       w_ex_is_mdu;
  logic       w_new_is_mdu;
  logic       w_wb_capable;

  assign w_is_ls      = (r_opcode == OPCODE_LOAD) || (r_opcode == OPCODE_STORE);
  assign w_ex_is_mdu  = (r_opcode == OPCODE_ALR) && (r_func7 == 7'b0000001);
  assign w_new_is_mdu = (id_opcode_in == OPCODE_ALR) && (id_func7_in == 7'b0000001);
  assign w_wb_capable = r_rd_en && (r_rd_addr != X0) &&
                        (r_opcode != OPCODE_STORE) && (r_opcode != OPCODE_BRANCH);
  // A retiring load whose destination feeds the next instruction forces one bubble.
  assign w_hazard     = (r_opcode == OPCODE_LOAD) && r_rd_en && (r_rd_addr != X0) &&
                        ((id_rs1_addr_in == r_rd_addr) || (id_rs2_addr_in == r_rd_addr));

  // Next-state, retirement and handshake decode.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_flush      = 1'b0;
    w_start      = 1'b0;
    w_retire     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
      end
      ST_EXEC: begin
        if (alu_branch_flag_in) begin
          w_retire     = 1'b1;
          w_flush      = 1'b1;
          w_next_state = ST_FLUSH;
        end else if (w_is_ls && !mem_ready_in) begin
          w_next_state = ST_MEM;
        end else begin
          w_retire     = 1'b1;
          w_ready      = !w_hazard;
          w_next_state = ST_IDLE;
        end
      end
      ST_MDU: begin
        w_start = (r_mdu_cnt == 6'd0) && w_ex_is_mdu;
        if (mdu_done_in) begin
          w_retire     = 1'b1;
          w_next_state = ST_IDLE;
        end else if (r_mdu_cnt == MDU_LIMIT) begin
          w_retire     = 1'b1;
          w_timeout    = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_MDU;
        end
      end
      ST_MEM: begin
        if (mem_ready_in) begin
          w_retire     = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_MEM;
        end
      end
      ST_FLUSH: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    w_accept = id_valid_in && w_ready && rst_n;
    if (w_accept) begin
      w_next_state = w_new_is_mdu ? ST_MDU : ST_EXEC;
    end else begin
      w_next_state = w_next_state;
    end
  end

  assign id_ready_out   = w_ready && rst_n;
  assign flush_out      = w_flush;
  assign mdu_start_out  = w_start;
  assign wb_en_out      = w_retire && !w_timeout && w_wb_capable;
  assign wb_rd_addr_out = r_rd_addr;
  assign ex_valid_out   = r_ex_valid;
  assign retire_cnt_out = r_retire_cnt;
  assign exu_err_out    = r_err;

  // State, EX register, MDU wait counter, retire counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_opcode     <= 7'd0;
      r_func7      <= 7'd0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= X0;
      r_mdu_cnt    <= 6'd0;
      r_retire_cnt <= 32'd0;
      r_err        <= 1'b0;
      r_ex_valid   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_ex_valid <= (w_next_state == ST_EXEC) || (w_next_state == ST_MDU) ||
                    (w_next_state == ST_MEM);
      if (w_accept) begin
        r_opcode  <= id_opcode_in;
        r_func7   <= id_func7_in;
        r_rd_en   <= id_rd_en_in;
        r_rd_addr <= id_rd_addr_in;
        r_mdu_cnt <= 6'd0;
      end else if ((r_state == ST_MDU) && !mdu_done_in && (r_mdu_cnt != MDU_LIMIT)) begin
        r_mdu_cnt <= r_mdu_cnt + 6'd1;
      end else begin
        r_mdu_cnt <= r_mdu_cnt;
      end
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end else begin
        r_retire_cnt <= r_retire_cnt;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
    end
  end

endmodule

// File: tb/tb_exu_ctrl.sv
// Directed scenarios followed by randomized traffic, checked against an
// instruction-lifetime reference model (in-flight instruction plus its age).
module tb_exu_ctrl;

  localparam logic [6:0] OP_ALR   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid_in;
  logic        id_ready_out;
  logic [6:0]  id_opcode_in;
  logic [6:0]  id_func7_in;
  logic        id_rd_en_in;
  logic [4:0]  id_rd_addr_in;
  logic [4:0]  id_rs1_addr_in;
  logic [4:0]  id_rs2_addr_in;
  logic        alu_branch_flag_in;
  logic        mem_ready_in;
  logic        mdu_start_out;
  logic        mdu_done_in;
  logic        ex_valid_out;
  logic        flush_out;
  logic        wb_en_out;
  logic [4:0]  wb_rd_addr_out;
  logic [31:0] retire_cnt_out;
  logic        exu_err_out;

  exu_ctrl #(.XREG_ADDRWIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_in(id_valid_in), .id_ready_out(id_ready_out),
    .id_opcode_in(id_opcode_in), .id_func7_in(id_func7_in),
    .id_rd_en_in(id_rd_en_in), .id_rd_addr_in(id_rd_addr_in),
    .id_rs1_addr_in(id_rs1_addr_in), .id_rs2_addr_in(id_rs2_addr_in),
    .alu_branch_flag_in(alu_branch_flag_in), .mem_ready_in(mem_ready_in),
    .mdu_start_out(mdu_start_out), .mdu_done_in(mdu_done_in),
    .ex_valid_out(ex_valid_out), .flush_out(flush_out),
    .wb_en_out(wb_en_out), .wb_rd_addr_out(wb_rd_addr_out),
    .retire_cnt_out(retire_cnt_out), .exu_err_out(exu_err_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the instruction in flight, how many cycles it has spent in EX,
  // whether a flush cycle is pending, and the architectural counters.
  logic        m_busy = 1'b0;
  int          m_age = 0;
  logic [6:0]  m_op = 7'd0;
  logic [6:0]  m_f7 = 7'd0;
  logic        m_rden = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic        m_flush_pend = 1'b0;
  logic [31:0] m_cnt = 32'd0;
  logic        m_err = 1'b0;

  logic s_ready, s_flush, s_wb, s_start;
  logic [4:0] s_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    logic e_ready, e_flush, e_wb, e_start, e_ret, e_to, e_acc, mdu, ls;
    s_ready = id_ready_out; s_flush = flush_out; s_wb = wb_en_out;
    s_start = mdu_start_out; s_addr = wb_rd_addr_out;
    if (!rst_n) begin
      m_busy = 1'b0; m_age = 0; m_flush_pend = 1'b0; m_cnt = 32'd0; m_err = 1'b0;
      m_op = 7'd0; m_f7 = 7'd0; m_rden = 1'b0; m_rd = 5'd0;
      chk("rst_ready", {31'd0, id_ready_out}, 32'd0);
      chk("rst_flush", {31'd0, flush_out}, 32'd0);
      chk("rst_wb", {31'd0, wb_en_out}, 32'd0);
      chk("rst_start", {31'd0, mdu_start_out}, 32'd0);
      chk("rst_exv", {31'd0, ex_valid_out}, 32'd0);
      chk("rst_cnt", retire_cnt_out, 32'd0);
      chk("rst_err", {31'd0, exu_err_out}, 32'd0);
    end else begin
      chk("exv", {31'd0, ex_valid_out}, {31'd0, m_busy});
      chk("cnt", retire_cnt_out, m_cnt);
      chk("err", {31'd0, exu_err_out}, {31'd0, m_err});
      e_ready = 1'b0; e_flush = 1'b0; e_wb = 1'b0; e_start = 1'b0; e_ret = 1'b0; e_to = 1'b0;
      mdu = (m_op == OP_ALR) && (m_f7 == 7'd1);
      ls  = (m_op == OP_LOAD) || (m_op == OP_STORE);
      if (m_flush_pend) begin
        e_ready = 1'b0;
      end else if (!m_busy) begin
        e_ready = 1'b1;
      end else if (mdu) begin
        e_start = (m_age == 0);
        if (mdu_done_in) e_ret = 1'b1;
        else if (m_age == 63) begin e_ret = 1'b1; e_to = 1'b1; end
      end else if (m_age == 0 && alu_branch_flag_in) begin
        e_ret = 1'b1; e_flush = 1'b1;
      end else if (ls && !mem_ready_in) begin
        e_ret = 1'b0;
      end else begin
        e_ret = 1'b1;
        if (m_age == 0)
          e_ready = !((m_op == OP_LOAD) && m_rden && m_rd != 5'd0 &&
                      (id_rs1_addr_in == m_rd || id_rs2_addr_in == m_rd));
      end
      e_wb = e_ret && !e_to && m_rden && (m_rd != 5'd0) && (m_op != OP_STORE) && (m_op != OP_BR);
      chk("ready", {31'd0, id_ready_out}, {31'd0, e_ready});
      chk("flush", {31'd0, flush_out}, {31'd0, e_flush});
      chk("wb_en", {31'd0, wb_en_out}, {31'd0, e_wb});
      chk("start", {31'd0, mdu_start_out}, {31'd0, e_start});
      if (e_wb) chk("wb_addr", {27'd0, wb_rd_addr_out}, {27'd0, m_rd});
      e_acc = id_valid_in && e_ready;
      if (e_ret) begin m_cnt = m_cnt + 32'd1; m_busy = 1'b0; end
      if (e_to) m_err = 1'b1;
      m_flush_pend = e_flush;
      if (e_acc) begin
        m_busy = 1'b1; m_age = 0; m_op = id_opcode_in; m_f7 = id_func7_in;
        m_rden = id_rd_en_in; m_rd = id_rd_addr_in;
      end else if (m_busy) begin
        m_age++;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [6:0] op, input logic [6:0] f7,
                     input logic rde, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic br, input logic mr, input logic dn);
    id_valid_in = v; id_opcode_in = op; id_func7_in = f7; id_rd_en_in = rde;
    id_rd_addr_in = rd; id_rs1_addr_in = rs1; id_rs2_addr_in = rs2;
    alu_branch_flag_in = br; mem_ready_in = mr; mdu_done_in = dn;
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic br, input logic mr, input logic dn);
    cyc(1'b0, OP_IMM, 7'd0, 1'b0, 5'd0, 5'd0, 5'd0, br, mr, dn);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int n_start;
    logic [6:0] ops [7];
    ops[0] = OP_ALR; ops[1] = OP_IMM; ops[2] = OP_LOAD; ops[3] = OP_STORE;
    ops[4] = OP_BR; ops[5] = OP_JALR; ops[6] = OP_LUI;
    #1;
    do_reset();

    // Back-to-back ADDI x1, ADDI x2
    cyc(1'b1, OP_IMM, 7'd0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("addi_acc", {31'd0, s_ready}, 32'd1);
    cyc(1'b1, OP_IMM, 7'd0, 1'b1, 5'd2, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("addi1_wb", {31'd0, s_wb}, 32'd1);
    chk("addi1_addr", {27'd0, s_addr}, 32'd1);
    chk("addi_nostall", {31'd0, s_ready}, 32'd1);
    idle(1'b0, 1'b1, 1'b0);
    chk("addi2_wb", {31'd0, s_wb}, 32'd1);
    chk("addi2_addr", {27'd0, s_addr}, 32'd2);
    chk("addi_cnt", retire_cnt_out, 32'd2);

    // LOAD x5 then ADD x6,x5,x7: one bubble
    cyc(1'b1, OP_LOAD, 7'd0, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, OP_ALR, 7'd0, 1'b1, 5'd6, 5'd5, 5'd7, 1'b0, 1'b1, 1'b0);
    chk("lu_bubble", {31'd0, s_ready}, 32'd0);
    chk("lu_load_wb", {31'd0, s_wb}, 32'd1);
    cyc(1'b1, OP_ALR, 7'd0, 1'b1, 5'd6, 5'd5, 5'd7, 1'b0, 1'b1, 1'b0);
    chk("lu_reaccept", {31'd0, s_ready}, 32'd1);
    idle(1'b0, 1'b1, 1'b0);
    chk("lu_add_wb", {31'd0, s_wb}, 32'd1);
    chk("lu_add_addr", {27'd0, s_addr}, 32'd6);
    // Same with LOAD x0: no bubble
    cyc(1'b1, OP_LOAD, 7'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, OP_ALR, 7'd0, 1'b1, 5'd6, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0);
    chk("lx0_nobubble", {31'd0, s_ready}, 32'd1);
    chk("lx0_nowb", {31'd0, s_wb}, 32'd0);
    idle(1'b0, 1'b1, 1'b0);
    chk("lx0_add_wb", {31'd0, s_wb}, 32'd1);

    // JALR x1 redirect
    cyc(1'b1, OP_JALR, 7'd0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    chk("jalr_wb", {31'd0, s_wb}, 32'd1);
    chk("jalr_flush", {31'd0, s_flush}, 32'd1);
    chk("jalr_rdy", {31'd0, s_ready}, 32'd0);
    cyc(1'b1, OP_IMM, 7'd0, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("flushst_rdy", {31'd0, s_ready}, 32'd0);
    chk("flushst_flush", {31'd0, s_flush}, 32'd0);
    cyc(1'b1, OP_IMM, 7'd0, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("post_flush_rdy", {31'd0, s_ready}, 32'd1);
    idle(1'b0, 1'b1, 1'b0);

    // MUL, done after 5 cycles
    n_start = 0;
    cyc(1'b1, OP_ALR, 7'd1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0, 1'b1, 1'b0);
      n_start += int'(s_start);
    end
    idle(1'b0, 1'b1, 1'b1);
    n_start += int'(s_start);
    chk("mul_wb", {31'd0, s_wb}, 32'd1);
    chk("mul_starts", n_start, 32'd1);

    // MUL timeout
    do_reset();
    cyc(1'b1, OP_ALR, 7'd1, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 64; k++) begin
      idle(1'b0, 1'b1, 1'b0);
      if (k == 63) chk("to_wb", {31'd0, s_wb}, 32'd0);
    end
    chk("to_err", {31'd0, exu_err_out}, 32'd1);
    chk("to_cnt", retire_cnt_out, 32'd1);
    chk("to_exv", {31'd0, ex_valid_out}, 32'd0);

    // STORE with memory stalling
    do_reset();
    cyc(1'b1, OP_STORE, 7'd0, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, OP_IMM, 7'd0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("mem_rdy", {31'd0, s_ready}, 32'd0);
    end
    cyc(1'b1, OP_IMM, 7'd0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("mem_last_rdy", {31'd0, s_ready}, 32'd0);
    chk("store_nowb", {31'd0, s_wb}, 32'd0);
    chk("store_cnt", retire_cnt_out, 32'd1);
    // Reset during MEM abandons the store
    cyc(1'b1, OP_STORE, 7'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    chk("memrst_cnt", retire_cnt_out, 32'd0);
    chk("memrst_exv", {31'd0, ex_valid_out}, 32'd0);
    cyc(1'b1, OP_IMM, 7'd0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("memrst_rdy", {31'd0, s_ready}, 32'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] op, f7;
      op = ops[$urandom_range(6, 0)];
      f7 = (op == OP_ALR && $urandom_range(2, 0) == 0) ? 7'd1 : 7'd0;
      rst_n = ($urandom_range(299, 0) != 0);
      cyc(1'($urandom_range(3, 0) != 0), op, f7, 1'($urandom_range(1, 0)),
          5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
          1'($urandom_range(7, 0) == 0), 1'($urandom_range(3, 0) != 0),
          1'($urandom_range(3, 0) == 0));
      rst_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
